// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: sync, data-enable, coordinates, line/frame
// strobes and a frame counter, all delayed equally by 1+PIPE_DELAY enabled cycles.
module vga_timing_gen #(
   parameter int CNT_W      = 10,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int HS_POL     = 0,
   parameter int VS_POL     = 0,
   parameter int PIPE_DELAY = 0,
   parameter int FRAME_W    = 16
) (
   input  logic               pclk,
   input  logic               reset_n,
   input  logic               ce,
   output logic               hsync,
   output logic               vsync,
   output logic               valid,
   output logic [CNT_W-1:0]   h_cnt,
   output logic [CNT_W-1:0]   v_cnt,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int H_T = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_T = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_T > (1 << CNT_W)) begin : g_h_total_chk
      $error("vga_timing_gen: horizontal total does not fit in CNT_W bits");
   end
   if (V_T > (1 << CNT_W)) begin : g_v_total_chk
      $error("vga_timing_gen: vertical total does not fit in CNT_W bits");
   end
   if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_delay_chk
      $error("vga_timing_gen: PIPE_DELAY must be within 0..15");
   end

   // Window bounds are one bit wider so a window may end exactly at 2^CNT_W.
   localparam logic [CNT_W:0] H_ACT_E = (CNT_W+1)'(H_ACTIVE);
   localparam logic [CNT_W:0] H_SS_E  = (CNT_W+1)'(H_ACTIVE + H_FP);
   localparam logic [CNT_W:0] H_SE_E  = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W:0] V_ACT_E = (CNT_W+1)'(V_ACTIVE);
   localparam logic [CNT_W:0] V_SS_E  = (CNT_W+1)'(V_ACTIVE + V_FP);
   localparam logic [CNT_W:0] V_SE_E  = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_T - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_T - 1);

   localparam logic HS_ON  = 1'(HS_POL);
   localparam logic HS_OFF = ~HS_ON;
   localparam logic VS_ON  = 1'(VS_POL);
   localparam logic VS_OFF = ~VS_ON;

   typedef struct packed {
      logic               hs;
      logic               vs;
      logic               act;
      logic [CNT_W-1:0]   x;
      logic [CNT_W-1:0]   y;
      logic               ls;
      logic               fs;
      logic [FRAME_W-1:0] fc;
   } stage_t;

   localparam stage_t STAGE_IDLE = stage_t'({HS_OFF, VS_OFF, {(1 + 2*CNT_W + 2 + FRAME_W){1'b0}}});

   logic [CNT_W-1:0]   hc_q, hc_d;
   logic [CNT_W-1:0]   vc_q, vc_d;
   logic [FRAME_W-1:0] fc_q, fc_d;
   logic [CNT_W:0]     hc_e, vc_e;
   stage_t             dec_d;
   stage_t             pipe_q [PIPE_DELAY+1];
   logic               fin_ls, fin_fs;
   logic               ls_q, fs_q;

   always_comb begin
      hc_d = hc_q;
      vc_d = vc_q;
      fc_d = fc_q;
      if (hc_q == H_LAST) begin
         hc_d = '0;
         if (vc_q == V_LAST) begin
            vc_d = '0;
            fc_d = fc_q + 1'b1;
         end else begin
            vc_d = vc_q + 1'b1;
         end
      end else begin
         hc_d = hc_q + 1'b1;
      end
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         hc_q <= '0;
         vc_q <= '0;
         fc_q <= '0;
      end else if (ce) begin
         hc_q <= hc_d;
         vc_q <= vc_d;
         fc_q <= fc_d;
      end
   end

   assign hc_e = {1'b0, hc_q};
   assign vc_e = {1'b0, vc_q};

   // The count travels with the pixel, so it is already bumped when (0,0) is decoded.
   always_comb begin
      dec_d     = STAGE_IDLE;
      dec_d.act = (hc_e < H_ACT_E) && (vc_e < V_ACT_E);
      dec_d.hs  = ((hc_e >= H_SS_E) && (hc_e < H_SE_E)) ? HS_ON : HS_OFF;
      dec_d.vs  = ((vc_e >= V_SS_E) && (vc_e < V_SE_E)) ? VS_ON : VS_OFF;
      dec_d.x   = dec_d.act ? hc_q : '0;
      dec_d.y   = dec_d.act ? vc_q : '0;
      dec_d.ls  = (hc_q == '0);
      dec_d.fs  = (hc_q == '0) && (vc_q == '0);
      dec_d.fc  = fc_q;
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i <= PIPE_DELAY; i++) begin
            pipe_q[i] <= STAGE_IDLE;
         end
      end else if (ce) begin
         pipe_q[0] <= dec_d;
         for (int i = 1; i <= PIPE_DELAY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   if (PIPE_DELAY == 0) begin : g_fin_direct
      assign fin_ls = dec_d.ls;
      assign fin_fs = dec_d.fs;
   end else begin : g_fin_piped
      assign fin_ls = pipe_q[PIPE_DELAY-1].ls;
      assign fin_fs = pipe_q[PIPE_DELAY-1].fs;
   end

   // Strobes mirror what the final stage loads, but only for the one pclk after that ce.
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         ls_q <= 1'b0;
         fs_q <= 1'b0;
      end else begin
         ls_q <= ce & fin_ls;
         fs_q <= ce & fin_fs;
      end
   end

   assign hsync       = pipe_q[PIPE_DELAY].hs;
   assign vsync       = pipe_q[PIPE_DELAY].vs;
   assign valid       = pipe_q[PIPE_DELAY].act;
   assign h_cnt       = pipe_q[PIPE_DELAY].x;
   assign v_cnt       = pipe_q[PIPE_DELAY].y;
   assign frame_cnt   = pipe_q[PIPE_DELAY].fc;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

endmodule
